// File: rtl/stage4_memory_pkg.sv
// Shared encodings for the memory-access stage: bus op kinds, access sizes
// and the two-state bus-cycle FSM.
package stage4_memory_pkg;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

endpackage

// File: rtl/stage4_memory_mem_align.sv
// Byte-lane logic: store lane enables and replication, load lane extraction
// with sign/zero extension, and the misalignment check.
module stage4_memory_mem_align
  import stage4_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic        misaligned
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend by access size.
  // The unused encoding 2'b11 behaves as a word access.
  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    sel        = 4'b1111;
    wdata      = store_data;
    load_val   = shifted;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        sel      = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
        load_val = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        misaligned = addr_lo[0];
        sel        = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        load_val   = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/stage4_memory.sv
// Memory-access pipeline stage: passes ALU results through, runs loads and
// stores over a req/ack data bus, and stalls upstream while a cycle is open.
module stage4_memory
  import stage4_memory_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        do_wb_i,
  input  logic [4:0]  wb_reg_i,
  input  logic [31:0] alu_result_i,
  input  logic [1:0]  mem_op_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_signed_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        fault_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        do_wb_o,
  output logic [4:0]  wb_reg_o,
  output logic [31:0] wb_val_o
);

  logic        state;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_addr_lo;
  logic        lat_load;
  logic        lat_do_wb;
  logic [4:0]  lat_reg;

  logic [1:0]  align_size;
  logic        align_signed;
  logic [1:0]  align_addr_lo;
  logic [3:0]  align_sel;
  logic [31:0] align_wdata;
  logic [31:0] align_load_val;
  logic        align_misaligned;
  logic        mem_access;

  // One aligner serves both phases: live inputs when idle, latched access
  // attributes while waiting so the load lane is extracted at ack time.
  assign align_size    = (state == S_WAIT) ? lat_size    : mem_size_i;
  assign align_signed  = (state == S_WAIT) ? lat_signed  : mem_signed_i;
  assign align_addr_lo = (state == S_WAIT) ? lat_addr_lo : alu_result_i[1:0];

  stage4_memory_mem_align u_align (
    .size       (align_size),
    .is_signed  (align_signed),
    .addr_lo    (align_addr_lo),
    .store_data (store_data_i),
    .rdata      (dbus_rdata_i),
    .sel        (align_sel),
    .wdata      (align_wdata),
    .load_val   (align_load_val),
    .misaligned (align_misaligned)
  );

  assign mem_access = valid_i && (mem_op_i != MEM_NONE);

  assign stall_o = ((state == S_IDLE) && mem_access && !align_misaligned) ||
                   ((state == S_WAIT) && !dbus_ack_i);

  // Bus request fields are held untouched in S_WAIT until the ack edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      lat_size     <= 2'd0;
      lat_signed   <= 1'b0;
      lat_addr_lo  <= 2'd0;
      lat_load     <= 1'b0;
      lat_do_wb    <= 1'b0;
      lat_reg      <= 5'd0;
      fault_o      <= 1'b0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= 32'd0;
      dbus_sel_o   <= 4'd0;
      dbus_wdata_o <= 32'd0;
      do_wb_o      <= 1'b0;
      wb_reg_o     <= 5'd0;
      wb_val_o     <= 32'd0;
    end else begin
      fault_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_access && align_misaligned) begin
            fault_o <= 1'b1;
            do_wb_o <= 1'b0;
          end else if (mem_access) begin
            state        <= S_WAIT;
            lat_size     <= mem_size_i;
            lat_signed   <= mem_signed_i;
            lat_addr_lo  <= alu_result_i[1:0];
            lat_load     <= (mem_op_i != MEM_STORE);
            lat_do_wb    <= do_wb_i;
            lat_reg      <= wb_reg_i;
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= (mem_op_i == MEM_STORE);
            dbus_addr_o  <= {alu_result_i[31:2], 2'b00};
            dbus_sel_o   <= align_sel;
            dbus_wdata_o <= align_wdata;
            do_wb_o      <= 1'b0;
          end else if (valid_i) begin
            do_wb_o  <= do_wb_i;
            wb_reg_o <= wb_reg_i;
            wb_val_o <= alu_result_i;
          end else begin
            do_wb_o <= 1'b0;
          end
        end
        default: begin
          do_wb_o <= 1'b0;
          if (dbus_ack_i) begin
            state      <= S_IDLE;
            dbus_req_o <= 1'b0;
            if (lat_load) begin
              do_wb_o  <= lat_do_wb;
              wb_reg_o <= lat_reg;
              wb_val_o <= align_load_val;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage4_memory.sv
// Self-checking bench for stage4_memory: directed scenarios plus random
// instructions compared against a byte-oriented reference model.
module tb_stage4_memory;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic        do_wb_i;
  logic [4:0]  wb_reg_i;
  logic [31:0] alu_result_i;
  logic [1:0]  mem_op_i;
  logic [1:0]  mem_size_i;
  logic        mem_signed_i;
  logic [31:0] store_data_i;
  logic        stall_o;
  logic        fault_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;
  logic        do_wb_o;
  logic [4:0]  wb_reg_o;
  logic [31:0] wb_val_o;

  int errors = 0;
  int checks = 0;

  stage4_memory dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .do_wb_i      (do_wb_i),
    .wb_reg_i     (wb_reg_i),
    .alu_result_i (alu_result_i),
    .mem_op_i     (mem_op_i),
    .mem_size_i   (mem_size_i),
    .mem_signed_i (mem_signed_i),
    .store_data_i (store_data_i),
    .stall_o      (stall_o),
    .fault_o      (fault_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_sel_o   (dbus_sel_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_ack_i   (dbus_ack_i),
    .dbus_rdata_i (dbus_rdata_i),
    .do_wb_o      (do_wb_o),
    .wb_reg_o     (wb_reg_o),
    .wb_val_o     (wb_val_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int nBytes(input logic [1:0] size);
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
    return (int'(off) % nBytes(size)) != 0;
  endfunction

  function automatic logic [3:0] modelSel(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(off) && i < int'(off) + nBytes(size)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = data[8*(i % nBytes(size)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sgn,
                                            input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] v;
    logic [31:0] mask;
    int n;
    n    = nBytes(size);
    v    = rdata >> (8 * int'(off));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = v & mask;
    if (sgn && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Runs one instruction end to end, answering the bus after ackDelay wait cycles.
  task automatic applyStimulus(input logic valid, input logic doWb, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [1:0] op,
                               input logic [1:0] size, input logic sgn,
                               input logic [31:0] sdata, input int ackDelay,
                               input logic [31:0] rdata);
    logic isMem;
    logic mis;
    valid_i      = valid;
    do_wb_i      = doWb;
    wb_reg_i     = rd;
    alu_result_i = alu;
    mem_op_i     = op;
    mem_size_i   = size;
    mem_signed_i = sgn;
    store_data_i = sdata;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = $urandom;
    isMem = valid && (op != 2'd0);
    mis   = isMem && isMisaligned(size, alu[1:0]);
    #1;
    checkOutput("stall_at_issue", 32'(stall_o), 32'(isMem && !mis));
    if (!isMem || mis) begin
      @(posedge clk_i); #1;
      checkOutput("fault", 32'(fault_o), 32'(mis));
      checkOutput("req_no_mem", 32'(dbus_req_o), 32'd0);
      checkOutput("do_wb_single", 32'(do_wb_o), 32'(valid && !isMem && doWb));
      if (valid && !isMem) begin
        checkOutput("wb_reg_pass", 32'(wb_reg_o), 32'(rd));
        checkOutput("wb_val_pass", wb_val_o, alu);
      end
    end else begin
      @(posedge clk_i); #1;
      checkOutput("req_accept", 32'(dbus_req_o), 32'd1);
      checkOutput("we", 32'(dbus_we_o), 32'(op == 2'd2));
      checkOutput("addr", dbus_addr_o, {alu[31:2], 2'b00});
      checkOutput("sel", 32'(dbus_sel_o), 32'(modelSel(size, alu[1:0])));
      if (op == 2'd2) checkOutput("wdata", dbus_wdata_o, modelWdata(size, sdata));
      checkOutput("do_wb_wait", 32'(do_wb_o), 32'd0);
      checkOutput("fault_mem", 32'(fault_o), 32'd0);
      for (int i = 0; i < ackDelay; i++) begin
        checkOutput("stall_wait", 32'(stall_o), 32'd1);
        @(posedge clk_i); #1;
        checkOutput("req_hold", 32'(dbus_req_o), 32'd1);
        checkOutput("addr_hold", dbus_addr_o, {alu[31:2], 2'b00});
      end
      dbus_ack_i   = 1'b1;
      dbus_rdata_i = rdata;
      #1;
      checkOutput("stall_ack", 32'(stall_o), 32'd0);
      @(posedge clk_i); #1;
      dbus_ack_i = 1'b0;
      checkOutput("req_drop", 32'(dbus_req_o), 32'd0);
      checkOutput("do_wb_done", 32'(do_wb_o), 32'(op != 2'd2 && doWb));
      if (op != 2'd2) begin
        checkOutput("wb_reg_load", 32'(wb_reg_o), 32'(rd));
        checkOutput("wb_val_load", wb_val_o, modelLoad(size, sgn, alu[1:0], rdata));
      end
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    valid_i      = 1'b0;
    do_wb_i      = 1'b0;
    wb_reg_i     = 5'd0;
    alu_result_i = 32'd0;
    mem_op_i     = 2'd0;
    mem_size_i   = 2'd0;
    mem_signed_i = 1'b0;
    store_data_i = 32'd0;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = 32'd0;
    #3;
    checkOutput("rst_do_wb", 32'(do_wb_o), 32'd0);
    checkOutput("rst_req", 32'(dbus_req_o), 32'd0);
    checkOutput("rst_wb_val", wb_val_o, 32'd0);
    checkOutput("rst_addr", dbus_addr_o, 32'd0);
    checkOutput("rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;

    applyStimulus(1'b1, 1'b1, 5'd5, 32'h0000_1234, 2'd0, 2'd2, 1'b0, 32'd0, 0, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h0000_0100, 2'd1, 2'd2, 1'b0, 32'd0, 3, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h0000_0103, 2'd1, 2'd0, 1'b1, 32'd0, 0, 32'h8000_0000);
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h0000_0103, 2'd1, 2'd0, 1'b0, 32'd0, 1, 32'h8000_0000);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0000_0102, 2'd2, 2'd1, 1'b0, 32'h0000_ABCD, 2, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_0101, 2'd1, 2'd2, 1'b0, 32'd0, 0, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'h0000_0040, 2'd0, 2'd2, 1'b0, 32'd0, 0, 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd6, 32'h0000_0077, 2'd0, 2'd2, 1'b0, 32'd0, 0, 32'd0);

    // Stray ack while idle must not produce a writeback.
    valid_i    = 1'b0;
    dbus_ack_i = 1'b1;
    @(posedge clk_i); #1;
    dbus_ack_i = 1'b0;
    checkOutput("idle_ack_do_wb", 32'(do_wb_o), 32'd0);
    checkOutput("idle_ack_req", 32'(dbus_req_o), 32'd0);

    // Reset in the middle of a bus cycle, followed by a late ack.
    valid_i      = 1'b1;
    do_wb_i      = 1'b1;
    wb_reg_i     = 5'd11;
    alu_result_i = 32'h0000_0200;
    mem_op_i     = 2'd1;
    mem_size_i   = 2'd2;
    @(posedge clk_i); #1;
    checkOutput("mid_req", 32'(dbus_req_o), 32'd1);
    valid_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_req", 32'(dbus_req_o), 32'd0);
    checkOutput("mid_rst_addr", dbus_addr_o, 32'd0);
    checkOutput("mid_rst_sel", 32'(dbus_sel_o), 32'd0);
    checkOutput("mid_rst_wb_val", wb_val_o, 32'd0);
    checkOutput("mid_rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i        = 1'b0;
    dbus_ack_i   = 1'b1;
    dbus_rdata_i = 32'h1111_2222;
    @(posedge clk_i); #1;
    dbus_ack_i = 1'b0;
    checkOutput("late_ack_do_wb", 32'(do_wb_o), 32'd0);
    checkOutput("late_ack_req", 32'(dbus_req_o), 32'd0);

    for (int n = 0; n < 200; n++) begin
      applyStimulus(($urandom_range(0, 7) != 0), 1'($urandom), 5'($urandom),
                    $urandom, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                    1'($urandom), $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
